// File: rtl/epd_pkg.sv
// Shared EPD timing-controller definitions: FSM state encoding, default panel
// timing and a counter-width helper.
package epd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FSTART = 3'd1;
  localparam state_t ST_LDATA  = 3'd2;
  localparam state_t ST_LEND   = 3'd3;
  localparam state_t ST_FEND   = 3'd4;

  localparam int DEF_H_ACT   = 200;
  localparam int DEF_V_ACT   = 1200;
  localparam int DEF_LE_W    = 2;
  localparam int DEF_GCK_W   = 4;
  localparam int DEF_H_BLANK = 20;
  localparam int DEF_V_BLANK = 100;

  localparam int FSTART_LEN = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/epd_tcon_if.sv
// Pixel-word stream between the memory interface (master) and the TCON (slave).
interface epd_tcon_if;
  logic [63:0] pix_read;
  logic        pix_read_valid;
  logic        pix_read_ready;
  logic        vsync;

  modport master (output pix_read, pix_read_valid, input pix_read_ready, vsync);
  modport slave  (input pix_read, pix_read_valid, output pix_read_ready, vsync);
endinterface

// File: rtl/epd_serializer.sv
// Splits each 64-bit pixel word into four 16-bit source-driver slices and
// generates the SDCLK phase: data changes after even sub-counts, clock rises after odd.
module epd_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic [2:0]  sc,
  input  logic [63:0] word,
  input  logic        word_ok,
  output logic [15:0] sd,
  output logic        sdclk
);

  logic [63:0] shreg;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      sd    <= '0;
      sdclk <= 1'b0;
    end else if (active && !sc[0]) begin
      sdclk <= 1'b0;
      if (sc == 3'd0) begin
        // A missing word is replaced by zeros so the panel sees a no-change line.
        shreg <= word_ok ? word : '0;
        sd    <= word_ok ? word[15:0] : '0;
      end else begin
        sd <= shreg[{sc[2:1], 4'b0000} +: 16];
      end
    end else begin
      sdclk <= active;
    end
  end

endmodule

// File: rtl/epd_tcon.sv
// EPD timing controller: frame/line sequencing, source-driver data stream and
// gate-driver strobes, all outputs registered.
module epd_tcon
  import epd_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int LE_W    = DEF_LE_W,
  parameter int GCK_W   = DEF_GCK_W,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int V_BLANK = DEF_V_BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  epd_tcon_if.slave         pix,
  output logic [15:0]       EPD_SD,
  output logic              EPD_SDCLK,
  output logic              EPD_SDLE,
  output logic              EPD_SDOE,
  output logic              EPD_SDCE0,
  output logic              EPD_GDCLK,
  output logic              EPD_GDSP,
  output logic              EPD_GDOE,
  output logic              busy,
  output logic              underflow,
  output logic [7:0]        frame_cnt
);

  localparam int HW       = cnt_w(H_ACT);
  localparam int VW       = cnt_w(V_ACT);
  localparam int LEND_LEN = LE_W + GCK_W + H_BLANK;
  localparam int TMR_A    = (LEND_LEN > V_BLANK) ? LEND_LEN : V_BLANK;
  localparam int TMR_MAX  = (TMR_A > FSTART_LEN) ? TMR_A : FSTART_LEN;
  localparam int TW       = cnt_w(TMR_MAX);

  state_t          state, state_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [VW-1:0]   vcnt, vcnt_n;
  logic [2:0]      sc, sc_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic            ready, vsync_q;
  logic            le_on, gck_on;

  assign pix.pix_read_ready = ready;
  assign pix.vsync          = vsync_q;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    vcnt_n  = vcnt;
    sc_n    = sc;
    tmr_n   = tmr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_FSTART;
          tmr_n   = '0;
        end
      end
      ST_FSTART: begin
        if (tmr == TW'(FSTART_LEN - 1)) begin
          state_n = ST_LDATA;
          tmr_n   = '0;
          vcnt_n  = '0;
          hcnt_n  = '0;
          sc_n    = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_LDATA: begin
        sc_n = sc + 3'd1;
        if (sc == 3'd7) begin
          if (hcnt == HW'(H_ACT - 1)) begin
            state_n = ST_LEND;
            hcnt_n  = '0;
            tmr_n   = '0;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      ST_LEND: begin
        if (tmr == TW'(LEND_LEN - 1)) begin
          tmr_n = '0;
          if (vcnt == VW'(V_ACT - 1)) begin
            state_n = ST_FEND;
          end else begin
            vcnt_n  = vcnt + 1'b1;
            state_n = ST_LDATA;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_FEND: begin
        if (tmr == TW'(V_BLANK - 1)) begin
          state_n = ST_IDLE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up
  // with the cycle the state machine is in.
  assign le_on  = (state_n == ST_LEND) && (tmr_n < TW'(LE_W));
  assign gck_on = (state_n == ST_LEND) && (tmr_n >= TW'(LE_W)) &&
                  (tmr_n < TW'(LE_W + GCK_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      sc        <= '0;
      tmr       <= '0;
      ready     <= 1'b0;
      vsync_q   <= 1'b0;
      busy      <= 1'b0;
      EPD_SDOE  <= 1'b0;
      EPD_GDOE  <= 1'b0;
      EPD_SDCE0 <= 1'b1;
      EPD_SDLE  <= 1'b0;
      EPD_GDCLK <= 1'b0;
      EPD_GDSP  <= 1'b1;
      underflow <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      vcnt      <= vcnt_n;
      sc        <= sc_n;
      tmr       <= tmr_n;
      ready     <= (state_n == ST_LDATA) && (sc_n == 3'd0);
      vsync_q   <= (state == ST_IDLE) && start;
      busy      <= (state_n != ST_IDLE);
      EPD_SDOE  <= (state_n != ST_IDLE);
      EPD_GDOE  <= (state_n != ST_IDLE);
      EPD_SDCE0 <= (state_n != ST_LDATA);
      EPD_SDLE  <= le_on;
      EPD_GDCLK <= gck_on;
      EPD_GDSP  <= !(gck_on && (vcnt_n == '0));
      if ((state == ST_IDLE) && start)
        underflow <= 1'b0;
      else if (ready && !pix.pix_read_valid)
        underflow <= 1'b1;
      if ((state == ST_FEND) && (state_n == ST_IDLE))
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  epd_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state == ST_LDATA),
    .sc      (sc),
    .word    (pix.pix_read),
    .word_ok (ready && pix.pix_read_valid),
    .sd      (EPD_SD),
    .sdclk   (EPD_SDCLK)
  );

endmodule

// File: doc/epd_tcon.md
EPD_TCON -- requirements
Module: epd_tcon

Interface
REQ-001 SHALL have parameter H_ACT, default 200, meaning 64-bit words per line (8 px per SDCLK, 32 px per word).
REQ-002 SHALL have parameter V_ACT, default 1200, meaning active lines per frame.
REQ-003 SHALL have parameter LE_W, default 2, meaning EPD_SDLE high width in clocks.
REQ-004 SHALL have parameter GCK_W, default 4, meaning EPD_GDCLK high width in clocks.
REQ-005 SHALL have parameter H_BLANK, default 20, meaning idle clocks after GDCLK per line.
REQ-006 SHALL have parameter V_BLANK, default 100, meaning idle clocks after last line before frame end.
REQ-007 SHALL have ports, one per line: clk in 1 EPD-domain clock (clk_epd at top level); rst_n in 1 reset, asynchronous and active-low.
REQ-008 start in 1 one-cycle frame request; ignored unless state is IDLE.
REQ-009 pix_read in 64 pixel word from memif; pix_read_valid in 1; pix_read_ready out 1.
REQ-010 vsync out 1 one-cycle frame-start pulse to memif.
REQ-011 EPD_SD out 16; EPD_SDCLK, EPD_SDLE, EPD_SDOE, EPD_SDCE0, EPD_GDCLK, EPD_GDSP, EPD_GDOE out 1 each.
REQ-012 busy out 1 (state != IDLE); underflow out 1 sticky; frame_cnt out 8.

Function
REQ-013 FSM states SHALL be IDLE, FSTART, LDATA, LEND, FEND.
REQ-014 IDLE->FSTART on start; vsync SHALL be high for exactly the first FSTART cycle; underflow SHALL clear on that cycle.
REQ-015 FSTART SHALL last 2 clocks with EPD_GDOE=1 and EPD_SDOE=1, then enter LDATA with line counter vcnt=0.
REQ-016 LDATA SHALL use a word counter hcnt (0..H_ACT-1) and sub-counter sc (0..7); pix_read_ready SHALL be 1 only when sc==0.
REQ-017 A word transfers when pix_read_valid&&pix_read_ready; the word SHALL be latched and slices [15:0],[31:16],[47:32],[63:48] presented on EPD_SD in that order.
REQ-018 EPD_SD SHALL change on the clock after sc even values (sc=0,2,4,6), with EPD_SDCLK=0; EPD_SDCLK SHALL be 1 on the following clock; latency transfer->first EPD_SD slice is 1 clock.
REQ-019 If pix_read_valid==0 at sc==0, the word SHALL be treated as 64'h0 (no-change waveform), no pop occurs, underflow SHALL set, and timing SHALL not stall.
REQ-020 EPD_SDCE0 SHALL be 0 during LDATA and 1 otherwise.
REQ-021 LDATA SHALL last exactly 8*H_ACT clocks, then enter LEND.
REQ-022 LEND SHALL drive EPD_SDLE=1 for LE_W clocks, then EPD_GDCLK=1 for GCK_W clocks, then H_BLANK idle clocks.
REQ-023 EPD_GDSP SHALL be 0 during the GDCLK pulse of line 0 and 1 at all other times.
REQ-024 At LEND end: if vcnt==V_ACT-1 go FEND, else vcnt++ and return to LDATA.
REQ-025 FEND SHALL last V_BLANK clocks, then deassert EPD_GDOE/EPD_SDOE, increment frame_cnt (wraps 255->0), return to IDLE.
REQ-026 start asserted while busy SHALL have no effect; start in the IDLE-return cycle SHALL be honoured next cycle.
REQ-027 All outputs SHALL be registered; hcnt, vcnt widths SHALL be clog2 of their parameter, minimum 1.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, counters=0, EPD_SD=0, EPD_SDCLK/SDLE/SDOE/GDCLK/GDOE=0, EPD_SDCE0=1, EPD_GDSP=1, vsync=0, pix_read_ready=0, underflow=0, frame_cnt=0.
REQ-029 Reset mid-frame SHALL abort without completing the line; no partial word SHALL be popped after reset.

Structure
REQ-030 Shared package epd_pkg SHALL hold the FSM state type and default timing constants (H_ACT, V_ACT, LE_W, GCK_W, H_BLANK, V_BLANK).
REQ-031 The 64->16 slice register and SDCLK phase generation SHALL be one sub-module, epd_serializer.

Verification (H_ACT=2, V_ACT=3, LE_W=2, GCK_W=4, H_BLANK=3, V_BLANK=5)
REQ-032 start, valid always 1, words 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555 -> EPD_SD sequence 1111,2222,3333,4444,5555,6666,7777,8888 each with one SDCLK rise, 2 pops per line, 6 pops per frame.
REQ-033 Full frame -> vsync one pulse; 3 SDLE pulses of 2 clocks; 3 GDCLK pulses of 4 clocks; GDSP low only in first; frame duration 2+3*(16+2+4+3)+5=82 clocks; frame_cnt=1.
REQ-034 valid=0 at second word of line 1 -> EPD_SD=0 for 4 slices, underflow=1, line timing unchanged; next start clears underflow.
REQ-035 start pulsed during LDATA -> ignored, frame_cnt increments once only.
REQ-036 rst_n low at line 2 sc=3 -> all outputs at reset values immediately; after release start gives clean frame.
REQ-037 256 frames -> frame_cnt wraps to 0.
